// File: rtl/uivbuf_pkg.sv
// Shared types and helpers for the uivbuf frame-buffer index manager.
// Optional statistics counters are enabled by defining UIVBUF_STAT_EN.
package uivbuf_pkg;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } wr_state_t;

  localparam int STAT_W = 16;

  function automatic int idx_w(input int buf_num);
    return $clog2(buf_num);
  endfunction

endpackage

// File: rtl/uivbuf_mgr_if.sv
// Bus between the video writer/reader side (master) and uivbuf_mgr (slave).
// Optional statistics ports are present when UIVBUF_STAT_EN is defined.
//
// Signalling: there is no valid/ready back-pressure. wr_fs_i, wr_fe_i and rd_fs_i
// are single-cycle pulses that are always accepted on the rising edge where they
// are high. Every response (index change, wr_busy_o, rd_new_o/rd_rep_o pulses,
// counters) appears on the registered outputs exactly one cycle later.
interface uivbuf_mgr_if #(
  parameter int BUF_W = 8
);
  logic             wr_fs_i;
  logic             wr_fe_i;
  logic             rd_fs_i;
  logic [BUF_W-1:0] wr_bufn_o;
  logic [BUF_W-1:0] rd_bufn_o;
  logic             wr_busy_o;
  logic             rd_new_o;
  logic             rd_rep_o;
`ifdef UIVBUF_STAT_EN
  logic [15:0]      drop_cnt_o;
  logic [15:0]      rep_cnt_o;

  modport master (
    output wr_fs_i, wr_fe_i, rd_fs_i,
    input  wr_bufn_o, rd_bufn_o, wr_busy_o, rd_new_o, rd_rep_o,
    input  drop_cnt_o, rep_cnt_o
  );
  modport slave (
    input  wr_fs_i, wr_fe_i, rd_fs_i,
    output wr_bufn_o, rd_bufn_o, wr_busy_o, rd_new_o, rd_rep_o,
    output drop_cnt_o, rep_cnt_o
  );
`else
  modport master (
    output wr_fs_i, wr_fe_i, rd_fs_i,
    input  wr_bufn_o, rd_bufn_o, wr_busy_o, rd_new_o, rd_rep_o
  );
  modport slave (
    input  wr_fs_i, wr_fe_i, rd_fs_i,
    output wr_bufn_o, rd_bufn_o, wr_busy_o, rd_new_o, rd_rep_o
  );
`endif
endinterface

// File: rtl/uivbuf_pick.sv
// Combinational lowest-free buffer picker: returns the lowest index whose
// exclusion bit is clear (0 if every bit is set, which the caller never allows).
module uivbuf_pick
  import uivbuf_pkg::*;
#(
  parameter int BUF_NUM = 3,
  parameter int IDX_W   = idx_w(BUF_NUM)
) (
  input  logic [BUF_NUM-1:0] excl,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the top so the last hit written is the lowest free index.
  always_comb begin
    idx = '0;
    for (int i = BUF_NUM - 1; i >= 0; i--) begin
      if (!excl[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/uivbuf_mgr.sv
// N-buffer video frame-buffer index manager. Gives the writer a free buffer,
// publishes completed frames and hands the reader the newest complete frame,
// repeating the current one on underrun and dropping aborted frames.
// Define UIVBUF_STAT_EN to add saturating drop/repeat counters.
module uivbuf_mgr
  import uivbuf_pkg::*;
#(
  parameter int BUF_NUM = 3,
  parameter int BUF_W   = 8
) (
  input logic         ui_clk,
  input logic         ui_rst_n,
  uivbuf_mgr_if.slave bus
);

  localparam int IDX_W = idx_w(BUF_NUM);

  if (BUF_NUM < 3 || BUF_NUM > 16) begin : g_bad_buf_num
    $error("uivbuf_mgr: BUF_NUM must be in 3..16");
  end
  if (BUF_W < IDX_W) begin : g_bad_buf_w
    $error("uivbuf_mgr: BUF_W must be >= index width");
  end

  wr_state_t          state, state_nxt;
  logic [IDX_W-1:0]   wr_idx, rd_idx, last_idx;
  logic               last_vld;
  logic [IDX_W-1:0]   rd_nxt, last_nxt, cand, pick_idx;
  logic               last_vld_nxt, cand_vld;
  logic               pub, start, take, rep;
  logic [BUF_NUM-1:0] excl;
  logic               rd_new_q, rd_rep_q;

  // Writer state register.
  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) state <= W_IDLE;
    else           state <= state_nxt;
  end

  // Writer next state: a frame start always (re)enters BUSY, a frame end leaves it.
  always_comb begin
    state_nxt = state;
    case (state)
      W_IDLE:  if (bus.wr_fs_i) state_nxt = W_BUSY;
      W_BUSY:  if (bus.wr_fs_i) state_nxt = W_BUSY;
               else if (bus.wr_fe_i) state_nxt = W_IDLE;
      default: state_nxt = W_IDLE;
    endcase
  end

  // Writer control outputs: publish only a frame that was actually in progress.
  always_comb begin
    pub   = (state == W_BUSY) && bus.wr_fe_i;
    start = bus.wr_fs_i;
  end

  // Reader decision and exclusion mask; a same-cycle publish is visible to both.
  always_comb begin
    last_nxt     = pub ? wr_idx : last_idx;
    last_vld_nxt = pub | last_vld;
    cand         = last_nxt;
    cand_vld     = last_vld_nxt;
    take         = bus.rd_fs_i && cand_vld && (cand != rd_idx);
    rep          = bus.rd_fs_i && !take;
    rd_nxt       = take ? cand : rd_idx;
    excl         = (BUF_NUM'(1) << rd_idx) | (BUF_NUM'(1) << rd_nxt);
    if (last_vld_nxt) excl = excl | (BUF_NUM'(1) << last_nxt);
  end

  uivbuf_pick #(
    .BUF_NUM (BUF_NUM),
    .IDX_W   (IDX_W)
  ) u_pick (
    .excl (excl),
    .idx  (pick_idx)
  );

  // Index registers and reader pulses.
  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      wr_idx   <= '0;
      rd_idx   <= IDX_W'(BUF_NUM - 1);
      last_idx <= '0;
      last_vld <= 1'b0;
      rd_new_q <= 1'b0;
      rd_rep_q <= 1'b0;
    end else begin
      if (start) wr_idx <= pick_idx;
      rd_idx   <= rd_nxt;
      last_idx <= last_nxt;
      last_vld <= last_vld_nxt;
      rd_new_q <= take;
      rd_rep_q <= rep;
    end
  end

  assign bus.wr_bufn_o = BUF_W'(wr_idx);
  assign bus.rd_bufn_o = BUF_W'(rd_idx);
  assign bus.wr_busy_o = (state == W_BUSY);
  assign bus.rd_new_o  = rd_new_q;
  assign bus.rd_rep_o  = rd_rep_q;

`ifdef UIVBUF_STAT_EN
  logic              abort;
  logic [STAT_W-1:0] drop_cnt, rep_cnt;

  // An abort is a frame start while busy with no frame end to publish.
  always_comb begin
    abort = (state == W_BUSY) && bus.wr_fs_i && !bus.wr_fe_i;
  end

  // Saturating statistics counters.
  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      drop_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      if (abort && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      if (rep && (rep_cnt != '1))    rep_cnt  <= rep_cnt + 1'b1;
    end
  end

  assign bus.drop_cnt_o = drop_cnt;
  assign bus.rep_cnt_o  = rep_cnt;
`endif

endmodule

// File: tb/tb_uivbuf_mgr.sv
// Bench for uivbuf_mgr: directed BUF_NUM=3 scenarios checked through an expected
// queue, plus a BUF_NUM=5 random-pulse run with mid-frame resets.
module tb_uivbuf_mgr;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uivbuf_mgr_if #(.BUF_W(8)) bus3 ();
  uivbuf_mgr_if #(.BUF_W(8)) bus5 ();

  uivbuf_mgr #(.BUF_NUM(3), .BUF_W(8)) u_dut (
    .ui_clk   (clk),
    .ui_rst_n (rst_n),
    .bus      (bus3)
  );

  uivbuf_mgr #(.BUF_NUM(5), .BUF_W(8)) u_dut5 (
    .ui_clk   (clk),
    .ui_rst_n (rst_n),
    .bus      (bus5)
  );

  // scoreboard: {due_cycle[31:0], wr[7:0], rd[7:0], busy, new, rep}
  localparam int EW = 51;
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: compare the registered outputs once the pushed entry is due
  logic [EW-1:0] mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0][50:19] <= cyc) begin
      mon_e = exp_q.pop_front();
      chk("wr_bufn", 32'(bus3.wr_bufn_o), 32'(mon_e[18:11]));
      chk("rd_bufn", 32'(bus3.rd_bufn_o), 32'(mon_e[10:3]));
      chk("wr_busy", 32'(bus3.wr_busy_o), 32'(mon_e[2]));
      chk("rd_new",  32'(bus3.rd_new_o),  32'(mon_e[1]));
      chk("rd_rep",  32'(bus3.rd_rep_o),  32'(mon_e[0]));
    end
  end

  // driver: called at a negedge; one pulse cycle, expectation due after next posedge
  task automatic step(input logic fs, input logic fe, input logic rfs,
                      input logic [7:0] ew, input logic [7:0] er,
                      input logic eb, input logic en, input logic ep);
    bus3.wr_fs_i = fs;
    bus3.wr_fe_i = fe;
    bus3.rd_fs_i = rfs;
    exp_q.push_back({32'(cyc + 1), ew, er, eb, en, ep});
    @(negedge clk);
    bus3.wr_fs_i = 1'b0;
    bus3.wr_fe_i = 1'b0;
    bus3.rd_fs_i = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    // first cycle after release must show the reset state
    step(0, 0, 0, 8'd0, 8'd2, 0, 0, 0);
  endtask

  initial begin
    bus3.wr_fs_i = 1'b0; bus3.wr_fe_i = 1'b0; bus3.rd_fs_i = 1'b0;
    bus5.wr_fs_i = 1'b0; bus5.wr_fe_i = 1'b0; bus5.rd_fs_i = 1'b0;

    // 1: reset state, reader start with nothing published repeats buffer 2
    do_reset();
    step(0, 0, 1, 8'd0, 8'd2, 0, 0, 1);
    step(0, 0, 0, 8'd0, 8'd2, 0, 0, 0);

    // 2: publish frame 0, reader takes it, writer moves to 1
    do_reset();
    step(1, 0, 0, 8'd0, 8'd2, 1, 0, 0);
    step(0, 1, 0, 8'd0, 8'd2, 0, 0, 0);
    step(0, 0, 1, 8'd0, 8'd0, 0, 1, 0);
    step(1, 0, 0, 8'd1, 8'd0, 1, 0, 0);

    // 3: reader holds 2, writer cycles 0,1,0; reader gets newest complete (1)
    do_reset();
    step(1, 0, 0, 8'd0, 8'd2, 1, 0, 0);
    step(0, 1, 0, 8'd0, 8'd2, 0, 0, 0);
    step(1, 0, 0, 8'd1, 8'd2, 1, 0, 0);
    step(0, 1, 0, 8'd1, 8'd2, 0, 0, 0);
    step(1, 0, 0, 8'd0, 8'd2, 1, 0, 0);
    step(0, 0, 1, 8'd0, 8'd1, 1, 1, 0);
`ifdef UIVBUF_STAT_EN
    chk("drop_cnt_t3", 32'(bus3.drop_cnt_o), 32'd0);
`endif

    // 4: abort without frame end publishes nothing; reader repeats
    do_reset();
    step(1, 0, 0, 8'd0, 8'd2, 1, 0, 0);
    step(1, 0, 0, 8'd0, 8'd2, 1, 0, 0);
    step(0, 0, 1, 8'd0, 8'd2, 1, 0, 1);
`ifdef UIVBUF_STAT_EN
    chk("drop_cnt_t4", 32'(bus3.drop_cnt_o), 32'd1);
    chk("rep_cnt_t4",  32'(bus3.rep_cnt_o),  32'd1);
`endif

    // 5: wr=1 busy, rd=2, last=0; fe+fs+rd_fs together bypasses frame 1 to reader
    do_reset();
    step(1, 0, 0, 8'd0, 8'd2, 1, 0, 0);
    step(0, 1, 0, 8'd0, 8'd2, 0, 0, 0);
    step(1, 0, 0, 8'd1, 8'd2, 1, 0, 0);
    step(1, 1, 1, 8'd0, 8'd1, 1, 1, 0);
    // frame end in idle is ignored; reader then takes 0 and finally repeats it
    step(0, 1, 0, 8'd0, 8'd1, 0, 0, 0);
    step(0, 1, 0, 8'd0, 8'd1, 0, 0, 0);
    step(0, 0, 1, 8'd0, 8'd0, 0, 1, 0);
    step(0, 0, 1, 8'd0, 8'd0, 0, 0, 1);

    // drain the expected queue with a bound
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    // 6: BUF_NUM=5 random pulses with asynchronous resets mid-frame
    @(negedge clk);
    for (int n = 0; n < 3000; n++) begin
      if (bus5.wr_busy_o) chk("inv_wr_ne_rd", 32'(bus5.wr_bufn_o != bus5.rd_bufn_o), 32'd1);
      chk("range5", 32'((bus5.wr_bufn_o < 8'd5) && (bus5.rd_bufn_o < 8'd5)), 32'd1);
      chk("new_rep_excl", 32'(bus5.rd_new_o & bus5.rd_rep_o), 32'd0);
      if ($urandom_range(0, 199) == 0) begin
        bus5.wr_fs_i = 1'b0; bus5.wr_fe_i = 1'b0; bus5.rd_fs_i = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst5_wr",   32'(bus5.wr_bufn_o), 32'd0);
        chk("rst5_rd",   32'(bus5.rd_bufn_o), 32'd4);
        chk("rst5_busy", 32'(bus5.wr_busy_o), 32'd0);
        chk("rst5_new",  32'(bus5.rd_new_o),  32'd0);
        chk("rst5_rep",  32'(bus5.rd_rep_o),  32'd0);
`ifdef UIVBUF_STAT_EN
        chk("rst5_drop", 32'(bus5.drop_cnt_o), 32'd0);
        chk("rst5_repc", 32'(bus5.rep_cnt_o),  32'd0);
`endif
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
      end else begin
        bus5.wr_fs_i = ($urandom_range(0, 7) == 0);
        bus5.wr_fe_i = ($urandom_range(0, 5) == 0);
        bus5.rd_fs_i = ($urandom_range(0, 4) == 0);
        @(negedge clk);
      end
    end
    bus5.wr_fs_i = 1'b0; bus5.wr_fe_i = 1'b0; bus5.rd_fs_i = 1'b0;

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
